// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address-width derivation and parameter legality checks
// common to the single- and dual-clock FIFOs.
package fifo_pkg;

    function automatic int unsigned addrWidth(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit isPow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit paramsLegal(input int unsigned depth,
                                       input int unsigned afThresh,
                                       input int unsigned aeThresh);
        return (depth >= 2) && isPow2(depth)
            && (afThresh >= 1) && (afThresh <= depth)
            && (aeThresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// The array is deliberately not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = addrWidth(DEPTH)
) (
    input  logic                  wClk,
    input  logic                  wEn,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic [DATA_WIDTH-1:0] wData,
    input  logic [ADDR_WIDTH-1:0] rAddr,
    output logic [DATA_WIDTH-1:0] rData
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wClk) begin
        if (wEn) begin
            mem[wAddr] <= wData;
        end
    end

    assign rData = mem[rAddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered level and threshold flags.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags and clrErr.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        wEn,
    input  logic [DATA_WIDTH-1:0]       wData,
    output logic                        full,
    output logic                        almostFull,
    input  logic                        rEn,
    output logic [DATA_WIDTH-1:0]       rData,
    output logic                        empty,
    output logic                        almostEmpty,
    output logic [addrWidth(DEPTH):0]   level,
    input  logic                        clrErr,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned ADDR_WIDTH = addrWidth(DEPTH);
    localparam int unsigned LW         = ADDR_WIDTH + 1;

    if (!paramsLegal(DEPTH, AF_THRESH, AE_THRESH)) begin : gBadParams
        $error("sync_fifo: illegal DEPTH or threshold parameters");
    end

    logic [LW-1:0] wPtr, rPtr, wPtrNext, rPtrNext, levelNext;
    logic          wAccept, rAccept, memWrite;
    logic          fullNext, emptyNext, afNext, aeNext;

    // Accept decisions, next pointers/level and next flags; flush overrides requests.
    always_comb begin
        wAccept   = wEn && (!full || rEn);
        rAccept   = rEn && !empty;
        memWrite  = wAccept && !flush;
        wPtrNext  = wPtr;
        rPtrNext  = rPtr;
        levelNext = level;
        if (flush) begin
            wPtrNext  = '0;
            rPtrNext  = '0;
            levelNext = '0;
        end else begin
            if (wAccept) wPtrNext = wPtr + LW'(1);
            if (rAccept) rPtrNext = rPtr + LW'(1);
            levelNext = level + LW'(wAccept) - LW'(rAccept);
        end
        fullNext  = (levelNext == LW'(DEPTH));
        emptyNext = (levelNext == '0);
        afNext    = (levelNext >= LW'(AF_THRESH));
        aeNext    = (levelNext <= LW'(AE_THRESH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wPtr        <= '0;
            rPtr        <= '0;
            level       <= '0;
            full        <= 1'b0;
            almostFull  <= 1'b0;
            empty       <= 1'b1;
            almostEmpty <= 1'b1;
        end else begin
            wPtr        <= wPtrNext;
            rPtr        <= rPtrNext;
            level       <= levelNext;
            full        <= fullNext;
            almostFull  <= afNext;
            empty       <= emptyNext;
            almostEmpty <= aeNext;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic wReject, rReject, overflowNext, underflowNext;

    // A new error on the same edge as clrErr keeps the flag set.
    always_comb begin
        wReject       = wEn && !wAccept && !flush;
        rReject       = rEn && !rAccept && !flush;
        overflowNext  = clrErr ? 1'b0 : overflow;
        underflowNext = clrErr ? 1'b0 : underflow;
        if (wReject) overflowNext  = 1'b1;
        if (rReject) underflowNext = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflowNext;
            underflow <= underflowNext;
        end
    end
`else
    logic unusedClrErr;
    assign unusedClrErr = clrErr;
    assign overflow     = 1'b0;
    assign underflow    = 1'b0;
`endif

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uMem (
        .wClk  (clk),
        .wEn   (memWrite),
        .wAddr (wPtr[ADDR_WIDTH-1:0]),
        .wData (wData),
        .rAddr (rPtr[ADDR_WIDTH-1:0]),
        .rData (rData)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH=16, AF=14, AE=1).
// Error-flag expectations follow SYNC_FIFO_ERR_EN.
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, wEn, rEn, clrErr;
    logic [31:0] wData;
    logic [31:0] rData;
    logic        full, almostFull, empty, almostEmpty, overflow, underflow;
    logic [4:0]  level;

    int totalCnt = 0;
    int badCnt   = 0;

    sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wEn         (wEn),
        .wData       (wData),
        .full        (full),
        .almostFull  (almostFull),
        .rEn         (rEn),
        .rData       (rData),
        .empty       (empty),
        .almostEmpty (almostEmpty),
        .level       (level),
        .clrErr      (clrErr),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks every registered output against the expected occupancy.
    task automatic chkFlags(input string tag, input int lvl, input bit ovf, input bit udf);
        chk({tag, ".level"}, 32'(level), 32'(lvl));
        chk({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
        chk({tag, ".full"}, 32'(full), 32'(lvl == 16));
        chk({tag, ".af"}, 32'(almostFull), 32'(lvl >= 14));
        chk({tag, ".ae"}, 32'(almostEmpty), 32'(lvl <= 1));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(udf));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wEn = 1'b0; rEn = 1'b0; clrErr = 1'b0; wData = '0;
        tick(); tick();
        chkFlags("reset", 0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Fill 0..15; almostFull first appears after the 14th write.
        for (int i = 0; i < 16; i++) begin
            wEn = 1'b1; wData = 32'(i);
            tick();
            chkFlags($sformatf("fill%0d", i), i + 1, 1'b0, 1'b0);
            chk("fill.head", rData, 32'd0);
        end
        wData = 32'h99;
        tick();
        wEn = 1'b0;
        chkFlags("ovf", 16, ERR, 1'b0);
        chk("ovf.head", rData, 32'd0);

        // Drain; the dropped 0x99 must never appear.
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.data", i), rData, 32'(i));
            rEn = 1'b1;
            tick();
            chk($sformatf("drain%0d.level", i), 32'(level), 32'(15 - i));
        end
        chkFlags("drained", 0, ERR, 1'b0);
        tick();
        chkFlags("udf", 0, ERR, ERR);

        // Underflow on the clrErr edge keeps underflow set; overflow clears.
        clrErr = 1'b1;
        tick();
        chkFlags("clrRace", 0, 1'b0, ERR);
        rEn = 1'b0;
        tick();
        clrErr = 1'b0;
        chkFlags("clr", 0, 1'b0, 1'b0);

        // Simultaneous write/read while full.
        for (int i = 0; i < 16; i++) begin
            wEn = 1'b1; wData = 32'(100 + i);
            tick();
        end
        wEn = 1'b0;
        chkFlags("refill", 16, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fullRw%0d.data", k), rData, 32'(100 + k));
            wEn = 1'b1; rEn = 1'b1; wData = 32'(200 + k);
            tick();
            chkFlags($sformatf("fullRw%0d", k), 16, 1'b0, 1'b0);
        end
        wEn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fullDrain%0d", i), rData, (i < 12) ? 32'(104 + i) : 32'(200 + i - 12));
            rEn = 1'b1;
            tick();
        end
        rEn = 1'b0;
        chkFlags("fullDrained", 0, 1'b0, 1'b0);

        // Simultaneous write/read while empty: write lands, read is rejected.
        wEn = 1'b1; rEn = 1'b1; wData = 32'hABCD;
        tick();
        wEn = 1'b0; rEn = 1'b0;
        chkFlags("emptyRw", 1, 1'b0, ERR);
        chk("emptyRw.data", rData, 32'hABCD);
        rEn = 1'b1; clrErr = 1'b1;
        tick();
        rEn = 1'b0; clrErr = 1'b0;
        chkFlags("emptyRwPop", 0, 1'b0, 1'b0);

        // Steady state at level 5 across several pointer wraps.
        for (int i = 0; i < 5; i++) begin
            wEn = 1'b1; wData = 32'(300 + i);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("wrap%0d.data", k), rData, 32'(300 + k));
            wEn = 1'b1; rEn = 1'b1; wData = 32'(305 + k);
            tick();
            chkFlags($sformatf("wrap%0d", k), 5, 1'b0, 1'b0);
        end
        rEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wData = 32'(345 + i);
            tick();
        end
        chkFlags("pre-flush", 9, 1'b0, 1'b0);
        chk("pre-flush.data", rData, 32'd340);

        // Flush outranks the concurrent write and raises no error.
        flush = 1'b1; wData = 32'h777;
        tick();
        flush = 1'b0; wEn = 1'b0;
        chkFlags("flush", 0, 1'b0, 1'b0);
        tick();
        chkFlags("postFlush", 0, 1'b0, 1'b0);

        // Asynchronous reset mid-burst, observed before the next edge.
        for (int i = 0; i < 3; i++) begin
            wEn = 1'b1; wData = 32'(500 + i);
            tick();
        end
        chk("burst.level", 32'(level), 32'd3);
        #2 rst = 1'b1;
        #1;
        chkFlags("asyncRst", 0, 1'b0, 1'b0);
        wEn = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chkFlags("postRst", 0, 1'b0, 1'b0);
        wEn = 1'b1; wData = 32'h5A5A;
        tick();
        wEn = 1'b0;
        chkFlags("firstAfterRst", 1, 1'b0, 1'b0);
        chk("firstAfterRst.data", rData, 32'h5A5A);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
